// File: rtl/cr_huf_comp_st_rd_sched.sv
// Read scheduler for the Huffman symbol-table queue: one header request per captured table,
// then streams entries 0..wr_ptr-1 to the symbol assembler and pulses read_done to free the queue.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

module cr_huf_comp_st_rd_sched #(
   parameter int DAT_WIDTH              = 10,
   parameter int MAX_SYMBOL_TABLE_DEPTH = 584,
   parameter int PTR_W                  = $clog2(MAX_SYMBOL_TABLE_DEPTH+1),
   parameter int ENT_W                  = 32,
   parameter int SEQ_W                  = `CREOLE_HC_SEQID_WIDTH
) (
   input  logic                 clk_gated,
   input  logic                 rst_n,
   input  logic                 sym_buf_full,
   input  logic [PTR_W-1:0]     sym_buf_wr_ptr,
   input  logic                 st_build_error,
   input  logic [SEQ_W-1:0]     st_seq_id,
   output logic [DAT_WIDTH-1:0] ent_rd_idx,
   input  logic [ENT_W-1:0]     ent_rd_data,
   output logic                 hdr_req,
   input  logic                 hdr_ack,
   output logic                 sa_sym_valid,
   input  logic                 sa_sym_ready,
   output logic [ENT_W-1:0]     sa_sym_data,
   output logic                 sa_sym_last,
   output logic [SEQ_W-1:0]     sa_seq_id,
   output logic                 sa_err,
   output logic                 sa_st_read_done
);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_STRM, S_DRAIN, S_DONE} state_e;

   localparam logic [PTR_W-1:0] MAX_P = PTR_W'(MAX_SYMBOL_TABLE_DEPTH);

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   rd_cnt_q, rd_cnt_d;
   logic [PTR_W-1:0]   wrp_q, wrp_d;
   logic [ENT_W-1:0]   data_q, data_d;
   logic               valid_q, valid_d;
   logic               last_q, last_d;
   logic [SEQ_W-1:0]   seq_q, seq_d;
   logic               err_q, err_d;

   logic start, abort, load, last_ent;

   assign start    = (state_q == S_IDLE) & sym_buf_full & ~sa_st_read_done;
   // Queue dropping full mid-table is a protocol violation; bail out without a done pulse.
   assign abort    = ~sym_buf_full & (state_q != S_IDLE) & (state_q != S_DONE);
   assign last_ent = (rd_cnt_q == wrp_q - PTR_W'(1));
   // First entry loads on the ack edge so the beat is valid one cycle after hdr_ack.
   assign load     = ~abort &
                     (((state_q == S_HDR) & hdr_ack & (wrp_q != '0)) |
                      ((state_q == S_STRM) & (~valid_q | sa_sym_ready)));

   always_ff @(posedge clk_gated or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = st_build_error ? S_DONE : S_HDR;
         S_HDR:   if (hdr_ack) state_d = (wrp_q == '0) ? S_DONE :
                                         (last_ent ? S_DRAIN : S_STRM);
         S_STRM:  if (load & last_ent) state_d = S_DRAIN;
         S_DRAIN: if (valid_q & sa_sym_ready) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   always_comb begin
      hdr_req         = (state_q == S_HDR);
      sa_st_read_done = (state_q == S_DONE);
   end

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wrp_d    = wrp_q;
      data_d   = data_q;
      valid_d  = valid_q;
      last_d   = last_q;
      seq_d    = seq_q;
      err_d    = start & st_build_error;
      if (start) begin
         seq_d    = st_seq_id;
         rd_cnt_d = '0;
         wrp_d    = (sym_buf_wr_ptr > MAX_P) ? MAX_P : sym_buf_wr_ptr;
      end
      if (abort) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end else if (load) begin
         data_d   = ent_rd_data;
         valid_d  = 1'b1;
         last_d   = last_ent;
         rd_cnt_d = rd_cnt_q + PTR_W'(1);
      end else if (valid_q & sa_sym_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_gated or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_q <= '0;
         wrp_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         seq_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wrp_q    <= wrp_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         seq_q    <= seq_d;
         err_q    <= err_d;
      end
   end

   assign ent_rd_idx   = rd_cnt_q[DAT_WIDTH-1:0];
   assign sa_sym_valid = valid_q;
   assign sa_sym_data  = data_q;
   assign sa_sym_last  = last_q;
   assign sa_seq_id    = seq_q;
   assign sa_err       = err_q;

endmodule
